// File: rtl/sdram_axi_arbiter.sv
// Two-master AXI4 arbiter in front of the single SDRAM controller slave port.
// One transaction at a time, round-robin over {in0_rd, in0_wr, in1_rd, in1_wr}.
module sdram_axi_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4
) (
  input  logic                clock,
  input  logic                reset,
  // master 0 (instruction fetch)
  input  logic                in0_arvalid,
  input  logic [ADDR_W-1:0]   in0_araddr,
  input  logic [ID_W-1:0]     in0_arid,
  input  logic [7:0]          in0_arlen,
  input  logic [2:0]          in0_arsize,
  input  logic [1:0]          in0_arburst,
  output logic                in0_arready,
  output logic                in0_rvalid,
  output logic [DATA_W-1:0]   in0_rdata,
  output logic [1:0]          in0_rresp,
  output logic                in0_rlast,
  output logic [ID_W-1:0]     in0_rid,
  input  logic                in0_rready,
  input  logic                in0_awvalid,
  input  logic [ADDR_W-1:0]   in0_awaddr,
  input  logic [ID_W-1:0]     in0_awid,
  input  logic [7:0]          in0_awlen,
  input  logic [2:0]          in0_awsize,
  input  logic [1:0]          in0_awburst,
  output logic                in0_awready,
  input  logic                in0_wvalid,
  input  logic [DATA_W-1:0]   in0_wdata,
  input  logic [DATA_W/8-1:0] in0_wstrb,
  input  logic                in0_wlast,
  output logic                in0_wready,
  output logic                in0_bvalid,
  output logic [1:0]          in0_bresp,
  output logic [ID_W-1:0]     in0_bid,
  input  logic                in0_bready,
  // master 1 (LSU)
  input  logic                in1_arvalid,
  input  logic [ADDR_W-1:0]   in1_araddr,
  input  logic [ID_W-1:0]     in1_arid,
  input  logic [7:0]          in1_arlen,
  input  logic [2:0]          in1_arsize,
  input  logic [1:0]          in1_arburst,
  output logic                in1_arready,
  output logic                in1_rvalid,
  output logic [DATA_W-1:0]   in1_rdata,
  output logic [1:0]          in1_rresp,
  output logic                in1_rlast,
  output logic [ID_W-1:0]     in1_rid,
  input  logic                in1_rready,
  input  logic                in1_awvalid,
  input  logic [ADDR_W-1:0]   in1_awaddr,
  input  logic [ID_W-1:0]     in1_awid,
  input  logic [7:0]          in1_awlen,
  input  logic [2:0]          in1_awsize,
  input  logic [1:0]          in1_awburst,
  output logic                in1_awready,
  input  logic                in1_wvalid,
  input  logic [DATA_W-1:0]   in1_wdata,
  input  logic [DATA_W/8-1:0] in1_wstrb,
  input  logic                in1_wlast,
  output logic                in1_wready,
  output logic                in1_bvalid,
  output logic [1:0]          in1_bresp,
  output logic [ID_W-1:0]     in1_bid,
  input  logic                in1_bready,
  // SDRAM controller slave
  output logic                out_arvalid,
  output logic [ADDR_W-1:0]   out_araddr,
  output logic [ID_W-1:0]     out_arid,
  output logic [7:0]          out_arlen,
  output logic [2:0]          out_arsize,
  output logic [1:0]          out_arburst,
  input  logic                out_arready,
  input  logic                out_rvalid,
  input  logic [DATA_W-1:0]   out_rdata,
  input  logic [1:0]          out_rresp,
  input  logic                out_rlast,
  input  logic [ID_W-1:0]     out_rid,
  output logic                out_rready,
  output logic                out_awvalid,
  output logic [ADDR_W-1:0]   out_awaddr,
  output logic [ID_W-1:0]     out_awid,
  output logic [7:0]          out_awlen,
  output logic [2:0]          out_awsize,
  output logic [1:0]          out_awburst,
  input  logic                out_awready,
  output logic                out_wvalid,
  output logic [DATA_W-1:0]   out_wdata,
  output logic [DATA_W/8-1:0] out_wstrb,
  output logic                out_wlast,
  input  logic                out_wready,
  input  logic                out_bvalid,
  input  logic [1:0]          out_bresp,
  input  logic [ID_W-1:0]     out_bid,
  output logic                out_bready
);

  typedef enum logic [1:0] {IDLE, RD, WR, WB} state_t;

  state_t     state, state_nxt;
  logic       gnt_m, gnt_nxt;
  logic [1:0] rr_ptr, rr_nxt;
  logic       ar_done, ar_done_nxt;
  logic       aw_done, aw_done_nxt;
  logic       w_done, w_done_nxt;

  logic [3:0] req;
  logic       found;
  logic [1:0] win;
  logic [1:0] idx;

  logic       in_rd, in_wr, in_wb;
  logic       g_arvalid, g_rready, g_awvalid, g_wvalid, g_bready;
  logic       ar_fire, r_last_fire, aw_fire, w_last_fire, b_fire;

  assign req = {in1_awvalid, in1_arvalid, in0_awvalid, in0_arvalid};

  // First requester at or after rr_ptr, wrapping 3 -> 0.
  always_comb begin
    found = 1'b0;
    win   = rr_ptr;
    idx   = rr_ptr;
    for (int i = 0; i < 4; i++) begin
      idx = rr_ptr + i[1:0];
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  assign in_rd = (state == RD);
  assign in_wr = (state == WR);
  assign in_wb = (state == WB);

  assign g_arvalid = gnt_m ? in1_arvalid : in0_arvalid;
  assign g_rready  = gnt_m ? in1_rready  : in0_rready;
  assign g_awvalid = gnt_m ? in1_awvalid : in0_awvalid;
  assign g_wvalid  = gnt_m ? in1_wvalid  : in0_wvalid;
  assign g_bready  = gnt_m ? in1_bready  : in0_bready;

  // Payloads follow the grant unconditionally; only valid/ready are gated.
  assign out_araddr  = gnt_m ? in1_araddr  : in0_araddr;
  assign out_arid    = gnt_m ? in1_arid    : in0_arid;
  assign out_arlen   = gnt_m ? in1_arlen   : in0_arlen;
  assign out_arsize  = gnt_m ? in1_arsize  : in0_arsize;
  assign out_arburst = gnt_m ? in1_arburst : in0_arburst;
  assign out_awaddr  = gnt_m ? in1_awaddr  : in0_awaddr;
  assign out_awid    = gnt_m ? in1_awid    : in0_awid;
  assign out_awlen   = gnt_m ? in1_awlen   : in0_awlen;
  assign out_awsize  = gnt_m ? in1_awsize  : in0_awsize;
  assign out_awburst = gnt_m ? in1_awburst : in0_awburst;
  assign out_wdata   = gnt_m ? in1_wdata   : in0_wdata;
  assign out_wstrb   = gnt_m ? in1_wstrb   : in0_wstrb;
  assign out_wlast   = gnt_m ? in1_wlast   : in0_wlast;

  assign out_arvalid = in_rd & g_arvalid & ~ar_done;
  assign in0_arready = in_rd & ~gnt_m & ~ar_done & out_arready;
  assign in1_arready = in_rd &  gnt_m & ~ar_done & out_arready;

  assign out_rready  = in_rd & g_rready;
  assign in0_rvalid  = in_rd & ~gnt_m & out_rvalid;
  assign in1_rvalid  = in_rd &  gnt_m & out_rvalid;
  assign in0_rdata   = out_rdata;
  assign in1_rdata   = out_rdata;
  assign in0_rresp   = out_rresp;
  assign in1_rresp   = out_rresp;
  assign in0_rlast   = out_rlast;
  assign in1_rlast   = out_rlast;
  assign in0_rid     = out_rid;
  assign in1_rid     = out_rid;

  assign out_awvalid = in_wr & g_awvalid & ~aw_done;
  assign in0_awready = in_wr & ~gnt_m & ~aw_done & out_awready;
  assign in1_awready = in_wr &  gnt_m & ~aw_done & out_awready;

  assign out_wvalid  = in_wr & g_wvalid & ~w_done;
  assign in0_wready  = in_wr & ~gnt_m & ~w_done & out_wready;
  assign in1_wready  = in_wr &  gnt_m & ~w_done & out_wready;

  assign out_bready  = in_wb & g_bready;
  assign in0_bvalid  = in_wb & ~gnt_m & out_bvalid;
  assign in1_bvalid  = in_wb &  gnt_m & out_bvalid;
  assign in0_bresp   = out_bresp;
  assign in1_bresp   = out_bresp;
  assign in0_bid     = out_bid;
  assign in1_bid     = out_bid;

  assign ar_fire     = out_arvalid & out_arready;
  assign r_last_fire = out_rvalid & out_rready & out_rlast;
  assign aw_fire     = out_awvalid & out_awready;
  assign w_last_fire = out_wvalid & out_wready & out_wlast;
  assign b_fire      = out_bvalid & out_bready;

  always_comb begin
    state_nxt   = state;
    gnt_nxt     = gnt_m;
    rr_nxt      = rr_ptr;
    ar_done_nxt = ar_done;
    aw_done_nxt = aw_done;
    w_done_nxt  = w_done;
    case (state)
      IDLE: begin
        ar_done_nxt = 1'b0;
        aw_done_nxt = 1'b0;
        w_done_nxt  = 1'b0;
        if (found) begin
          gnt_nxt   = win[1];
          rr_nxt    = win + 2'd1;
          state_nxt = win[0] ? WR : RD;
        end
      end
      RD: begin
        if (ar_fire) ar_done_nxt = 1'b1;
        if (r_last_fire) begin
          state_nxt   = IDLE;
          ar_done_nxt = 1'b0;
        end
      end
      WR: begin
        aw_done_nxt = aw_done | aw_fire;
        w_done_nxt  = w_done | w_last_fire;
        if (aw_done_nxt && w_done_nxt) state_nxt = WB;
      end
      WB: begin
        if (b_fire) begin
          state_nxt   = IDLE;
          aw_done_nxt = 1'b0;
          w_done_nxt  = 1'b0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      gnt_m   <= 1'b0;
      rr_ptr  <= 2'd0;
      ar_done <= 1'b0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      state   <= state_nxt;
      gnt_m   <= gnt_nxt;
      rr_ptr  <= rr_nxt;
      ar_done <= ar_done_nxt;
      aw_done <= aw_done_nxt;
      w_done  <= w_done_nxt;
    end
  end

endmodule

// File: tb/tb_sdram_axi_arbiter.sv
// Directed bench for sdram_axi_arbiter: the bench plays both masters and the SDRAM slave.
module tb_sdram_axi_arbiter;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int ID_W   = 4;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  logic in0_arvalid = 0, in0_arready, in0_rvalid, in0_rlast, in0_rready = 1;
  logic [ADDR_W-1:0] in0_araddr = 0, in0_awaddr = 0;
  logic [ID_W-1:0] in0_arid = 0, in0_rid, in0_awid = 0, in0_bid;
  logic [7:0] in0_arlen = 0, in0_awlen = 0;
  logic [2:0] in0_arsize = 3'd2, in0_awsize = 3'd2;
  logic [1:0] in0_arburst = 2'd1, in0_awburst = 2'd1, in0_rresp, in0_bresp;
  logic [DATA_W-1:0] in0_rdata, in0_wdata = 0;
  logic in0_awvalid = 0, in0_awready, in0_wvalid = 0, in0_wlast = 0, in0_wready;
  logic [DATA_W/8-1:0] in0_wstrb = 4'hF;
  logic in0_bvalid, in0_bready = 1;

  logic in1_arvalid = 0, in1_arready, in1_rvalid, in1_rlast, in1_rready = 1;
  logic [ADDR_W-1:0] in1_araddr = 0, in1_awaddr = 0;
  logic [ID_W-1:0] in1_arid = 0, in1_rid, in1_awid = 0, in1_bid;
  logic [7:0] in1_arlen = 0, in1_awlen = 0;
  logic [2:0] in1_arsize = 3'd2, in1_awsize = 3'd2;
  logic [1:0] in1_arburst = 2'd1, in1_awburst = 2'd1, in1_rresp, in1_bresp;
  logic [DATA_W-1:0] in1_rdata, in1_wdata = 0;
  logic in1_awvalid = 0, in1_awready, in1_wvalid = 0, in1_wlast = 0, in1_wready;
  logic [DATA_W/8-1:0] in1_wstrb = 4'hF;
  logic in1_bvalid, in1_bready = 1;

  logic out_arvalid, out_arready = 0, out_rvalid = 0, out_rlast = 0, out_rready;
  logic [ADDR_W-1:0] out_araddr, out_awaddr;
  logic [ID_W-1:0] out_arid, out_rid = 0, out_awid, out_bid = 0;
  logic [7:0] out_arlen, out_awlen;
  logic [2:0] out_arsize, out_awsize;
  logic [1:0] out_arburst, out_awburst, out_rresp = 0, out_bresp = 0;
  logic [DATA_W-1:0] out_rdata = 0, out_wdata;
  logic out_awvalid, out_awready = 0, out_wvalid, out_wlast, out_wready = 0;
  logic [DATA_W/8-1:0] out_wstrb;
  logic out_bvalid = 0, out_bready;

  int checks = 0;
  int errors = 0;

  sdram_axi_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W)) dut (
    .clock(clock), .reset(reset),
    .in0_arvalid(in0_arvalid), .in0_araddr(in0_araddr), .in0_arid(in0_arid),
    .in0_arlen(in0_arlen), .in0_arsize(in0_arsize), .in0_arburst(in0_arburst),
    .in0_arready(in0_arready), .in0_rvalid(in0_rvalid), .in0_rdata(in0_rdata),
    .in0_rresp(in0_rresp), .in0_rlast(in0_rlast), .in0_rid(in0_rid), .in0_rready(in0_rready),
    .in0_awvalid(in0_awvalid), .in0_awaddr(in0_awaddr), .in0_awid(in0_awid),
    .in0_awlen(in0_awlen), .in0_awsize(in0_awsize), .in0_awburst(in0_awburst),
    .in0_awready(in0_awready), .in0_wvalid(in0_wvalid), .in0_wdata(in0_wdata),
    .in0_wstrb(in0_wstrb), .in0_wlast(in0_wlast), .in0_wready(in0_wready),
    .in0_bvalid(in0_bvalid), .in0_bresp(in0_bresp), .in0_bid(in0_bid), .in0_bready(in0_bready),
    .in1_arvalid(in1_arvalid), .in1_araddr(in1_araddr), .in1_arid(in1_arid),
    .in1_arlen(in1_arlen), .in1_arsize(in1_arsize), .in1_arburst(in1_arburst),
    .in1_arready(in1_arready), .in1_rvalid(in1_rvalid), .in1_rdata(in1_rdata),
    .in1_rresp(in1_rresp), .in1_rlast(in1_rlast), .in1_rid(in1_rid), .in1_rready(in1_rready),
    .in1_awvalid(in1_awvalid), .in1_awaddr(in1_awaddr), .in1_awid(in1_awid),
    .in1_awlen(in1_awlen), .in1_awsize(in1_awsize), .in1_awburst(in1_awburst),
    .in1_awready(in1_awready), .in1_wvalid(in1_wvalid), .in1_wdata(in1_wdata),
    .in1_wstrb(in1_wstrb), .in1_wlast(in1_wlast), .in1_wready(in1_wready),
    .in1_bvalid(in1_bvalid), .in1_bresp(in1_bresp), .in1_bid(in1_bid), .in1_bready(in1_bready),
    .out_arvalid(out_arvalid), .out_araddr(out_araddr), .out_arid(out_arid),
    .out_arlen(out_arlen), .out_arsize(out_arsize), .out_arburst(out_arburst),
    .out_arready(out_arready), .out_rvalid(out_rvalid), .out_rdata(out_rdata),
    .out_rresp(out_rresp), .out_rlast(out_rlast), .out_rid(out_rid), .out_rready(out_rready),
    .out_awvalid(out_awvalid), .out_awaddr(out_awaddr), .out_awid(out_awid),
    .out_awlen(out_awlen), .out_awsize(out_awsize), .out_awburst(out_awburst),
    .out_awready(out_awready), .out_wvalid(out_wvalid), .out_wdata(out_wdata),
    .out_wstrb(out_wstrb), .out_wlast(out_wlast), .out_wready(out_wready),
    .out_bvalid(out_bvalid), .out_bresp(out_bresp), .out_bid(out_bid), .out_bready(out_bready)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  // Slave side of a granted read: AR handshake, then `beats` R beats ending in rlast.
  task automatic serve_read(input bit m, input logic [ID_W-1:0] id, input int beats, input bit keep);
    chk("rd_arvalid", out_arvalid, 1);
    chk("rd_arid", out_arid, id);
    chk("rd_awvalid_quiet", out_awvalid, 0);
    out_arready = 1; #1;
    chk("rd_arready_gnt", m ? in1_arready : in0_arready, 1);
    chk("rd_arready_other", m ? in0_arready : in1_arready, 0);
    tick();
    out_arready = 0;
    if (!keep) begin
      if (m) in1_arvalid = 0; else in0_arvalid = 0;
    end
    for (int b = 0; b < beats; b++) begin
      out_rvalid = 1; out_rid = id; out_rresp = 0;
      out_rdata = 32'hC000_0000 + b;
      out_rlast = (b == beats - 1);
      #1;
      chk("rd_rvalid_gnt", m ? in1_rvalid : in0_rvalid, 1);
      chk("rd_rvalid_other", m ? in0_rvalid : in1_rvalid, 0);
      chk("rd_rid", m ? in1_rid : in0_rid, id);
      tick();
    end
    out_rvalid = 0; out_rlast = 0;
  endtask

  // Slave side of a granted single-beat write: AW and W accepted together, then B.
  task automatic serve_write(input bit m, input logic [ID_W-1:0] id, input logic [1:0] resp,
                             input bit keep);
    chk("wr_awvalid", out_awvalid, 1);
    chk("wr_awid", out_awid, id);
    chk("wr_wvalid", out_wvalid, 1);
    chk("wr_arvalid_quiet", out_arvalid, 0);
    out_awready = 1; out_wready = 1; #1;
    chk("wr_awready_gnt", m ? in1_awready : in0_awready, 1);
    chk("wr_wready_gnt", m ? in1_wready : in0_wready, 1);
    chk("wr_wready_other", m ? in0_wready : in1_wready, 0);
    tick();
    out_awready = 0; out_wready = 0;
    if (!keep) begin
      if (m) begin in1_awvalid = 0; in1_wvalid = 0; end
      else   begin in0_awvalid = 0; in0_wvalid = 0; end
    end
    chk("wr_wb_bready", out_bready, 1);
    out_bvalid = 1; out_bid = id; out_bresp = resp; #1;
    chk("wr_bvalid_gnt", m ? in1_bvalid : in0_bvalid, 1);
    chk("wr_bvalid_other", m ? in0_bvalid : in1_bvalid, 0);
    chk("wr_bid", m ? in1_bid : in0_bid, id);
    chk("wr_bresp", m ? in1_bresp : in0_bresp, resp);
    tick();
    out_bvalid = 0;
  endtask

  initial begin
    // Reset state, with requests and responses already driven
    in0_arvalid = 1; in0_araddr = 32'hA000_0000; in0_arid = 4'h5; in0_arlen = 8'd3;
    out_rvalid = 1; out_bvalid = 1;
    tick(); tick();
    chk("rst_out_arvalid", out_arvalid, 0);
    chk("rst_in0_arready", in0_arready, 0);
    chk("rst_in0_rvalid", in0_rvalid, 0);
    chk("rst_out_rready", out_rready, 0);
    chk("rst_in1_bvalid", in1_bvalid, 0);
    chk("rst_out_bready", out_bready, 0);
    reset = 1; out_rvalid = 0; out_bvalid = 0; #1;
    chk("t1_arb_cycle", out_arvalid, 0);

    // 1: lone in0 4-beat read
    tick();
    chk("t1_arvalid", out_arvalid, 1);
    chk("t1_araddr", out_araddr, 32'hA000_0000);
    chk("t1_arlen", out_arlen, 3);
    out_arready = 1; #1;
    chk("t1_arready", in0_arready, 1);
    chk("t1_arready_in1", in1_arready, 0);
    tick();
    chk("t1_ar_once", out_arvalid, 0);
    chk("t1_arready_gated", in0_arready, 0);
    in0_arvalid = 0; out_arready = 0;
    for (int b = 0; b < 4; b++) begin
      out_rvalid = 1; out_rid = 4'h5; out_rdata = 32'h1000 + b;
      out_rlast = (b == 3); out_rresp = (b == 2) ? 2'b10 : 2'b00;
      #1;
      chk("t1_rvalid", in0_rvalid, 1);
      chk("t1_rdata", in0_rdata, 32'h1000 + b);
      chk("t1_rlast", in0_rlast, (b == 3));
      chk("t1_rresp", in0_rresp, (b == 2) ? 2'b10 : 2'b00);
      chk("t1_in1_rvalid", in1_rvalid, 0);
      tick();
    end
    out_rlast = 0; #1;
    chk("t1_idle_rvalid", in0_rvalid, 0);
    chk("t1_idle_rready", out_rready, 0);
    out_rvalid = 0;

    // 2a: simultaneous reads after reset -> in0 then in1
    do_reset();
    in0_arvalid = 1; in0_arid = 4'h1; in0_arlen = 0;
    in1_arvalid = 1; in1_arid = 4'h2; in1_arlen = 0;
    tick();
    serve_read(0, 4'h1, 1, 0);
    chk("t2a_idle_gap", out_arvalid, 0);
    tick();
    serve_read(1, 4'h2, 1, 0);

    // 4: in0 len=0 write, AW and W accepted in the same cycle, error response forwarded
    in0_awvalid = 1; in0_awid = 4'h7; in0_awlen = 0; in0_awaddr = 32'h0000_0040;
    in0_wvalid = 1; in0_wdata = 32'hDEAD_BEEF; in0_wlast = 1;
    tick();
    chk("t4_wdata", out_wdata, 32'hDEAD_BEEF);
    chk("t4_awaddr", out_awaddr, 32'h0000_0040);
    serve_write(0, 4'h7, 2'b10, 0);
    in0_wlast = 0;

    // 2b: rr_ptr now 2 -> in1 read first
    in0_arvalid = 1; in1_arvalid = 1;
    tick();
    serve_read(1, 4'h2, 1, 0);
    tick();
    serve_read(0, 4'h1, 1, 0);

    // 3: in1 len=1 write, slow AW ready, W beats late
    in1_awvalid = 1; in1_awid = 4'h9; in1_awlen = 1; in1_awaddr = 32'h0000_1000;
    tick();
    chk("t3_awvalid", out_awvalid, 1);
    chk("t3_awid", out_awid, 4'h9);
    chk("t3_wvalid_none", out_wvalid, 0);
    tick();
    chk("t3_awvalid_hold", out_awvalid, 1);
    out_awready = 1; #1;
    chk("t3_awready", in1_awready, 1);
    chk("t3_awready_in0", in0_awready, 0);
    tick();
    chk("t3_aw_once", out_awvalid, 0);
    chk("t3_awready_gated", in1_awready, 0);
    in1_awvalid = 0; out_awready = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t3_wait_bready", out_bready, 0);
    end
    in1_wvalid = 1; in1_wdata = 32'h11; in1_wlast = 0; #1;
    chk("t3_w0_valid", out_wvalid, 1);
    chk("t3_w0_noready", in1_wready, 0);
    tick();
    out_wready = 1; #1;
    chk("t3_w0_ready", in1_wready, 1);
    chk("t3_w0_data", out_wdata, 32'h11);
    tick();
    in1_wdata = 32'h22; in1_wlast = 1; #1;
    chk("t3_w1_data", out_wdata, 32'h22);
    chk("t3_w1_last", out_wlast, 1);
    chk("t3_still_wr", out_bready, 0);
    tick();
    chk("t3_no_dup_beat", out_wvalid, 0);
    chk("t3_wb_bready", out_bready, 1);
    in1_wvalid = 0; in1_wlast = 0; out_wready = 0;
    out_bvalid = 1; out_bid = 4'h9; out_bresp = 0; #1;
    chk("t3_bvalid", in1_bvalid, 1);
    chk("t3_bvalid_in0", in0_bvalid, 0);
    chk("t3_bid", in1_bid, 4'h9);
    tick();
    chk("t3_single_b", in1_bvalid, 0);
    out_bvalid = 0;

    // 5: all four requesters held valid -> rd0, wr0, rd1, wr1 repeating
    do_reset();
    in0_arid = 4'h1; in0_awid = 4'h2; in1_arid = 4'h3; in1_awid = 4'h4;
    in0_awlen = 0; in1_awlen = 0; in0_arlen = 0; in1_arlen = 0;
    in0_wlast = 1; in1_wlast = 1;
    in0_arvalid = 1; in0_awvalid = 1; in0_wvalid = 1;
    in1_arvalid = 1; in1_awvalid = 1; in1_wvalid = 1;
    for (int k = 0; k < 12; k++) begin
      tick();
      case (k % 4)
        0: serve_read(0, 4'h1, 1, 1);
        1: serve_write(0, 4'h2, 2'b00, 1);
        2: serve_read(1, 4'h3, 1, 1);
        default: serve_write(1, 4'h4, 2'b00, 1);
      endcase
    end
    in0_arvalid = 0; in0_awvalid = 0; in0_wvalid = 0; in0_wlast = 0;
    in1_arvalid = 0; in1_awvalid = 0; in1_wvalid = 0; in1_wlast = 0;
    tick();

    // 6: reset mid 8-beat read, then a fresh in1 write
    in0_arvalid = 1; in0_arid = 4'h6; in0_arlen = 8'd7;
    tick();
    chk("t6_arvalid", out_arvalid, 1);
    out_arready = 1;
    tick();
    out_arready = 0; in0_arvalid = 0;
    for (int b = 0; b < 3; b++) begin
      out_rvalid = 1; out_rid = 4'h6; out_rdata = 32'h200 + b; out_rlast = 0;
      tick();
    end
    #1;
    chk("t6_pre_rvalid", in0_rvalid, 1);
    reset = 0; #1;
    chk("t6_rst_rvalid", in0_rvalid, 0);
    chk("t6_rst_rready", out_rready, 0);
    chk("t6_rst_arvalid", out_arvalid, 0);
    tick();
    out_rvalid = 0; reset = 1;
    in1_awvalid = 1; in1_awid = 4'hA; in1_awlen = 0; in1_wvalid = 1; in1_wlast = 1;
    in1_wdata = 32'h5A5A_5A5A;
    tick();
    chk("t6_wdata", out_wdata, 32'h5A5A_5A5A);
    serve_write(1, 4'hA, 2'b00, 0);
    in1_wlast = 0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
